// File: rtl/sym_fir_serial.sv
// sym_fir_serial: folded symmetric FIR with a single serial MAC.
// One pre-add/multiply per cycle, saturating unsigned output.
module sym_fir_serial #(
  parameter int NTAPS = 39,
  parameter int W     = 12,
  parameter int CW    = 12,
  parameter int SHIFT = 0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [W-1:0]                      in_data,
  output logic                              in_ready,
  input  logic                              coef_we,
  input  logic [$clog2((NTAPS+1)/2)-1:0]    coef_addr,
  input  logic [CW-1:0]                     coef_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [W-1:0]                      out_data,
  output logic                              out_sat
);

  localparam int H   = (NTAPS + 1) / 2;
  localparam int AW  = $clog2(H);
  localparam int DW  = $clog2(NTAPS);
  localparam int PW  = W + 1;
  localparam int MW  = PW + CW;
  localparam int ACW = W + CW + $clog2(NTAPS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]   d [NTAPS];
  logic [CW-1:0]  c [H];
  logic [ACW-1:0] acc, acc_nx, res;
  logic [AW-1:0]  idx;
  logic           last;
  logic [DW-1:0]  ia, ib;
  logic [PW-1:0]  pre;
  logic [MW-1:0]  prod;
  logic           accept, cwr;
  logic [W-1:0]   res_data;
  logic           res_sat;

  // Fold mirror taps, multiply by shared coefficient, form saturated result.
  always_comb begin
    last     = (idx == AW'(H - 1));
    ia       = DW'(idx);
    ib       = DW'(NTAPS - 1) - ia;
    pre      = last ? {1'b0, d[ia]}
                    : {1'b0, d[ia]} + {1'b0, d[ib]};
    prod     = MW'(pre) * MW'(c[idx]);
    acc_nx   = acc + ACW'(prod);
    res      = acc_nx >> SHIFT;
    res_sat  = |(res >> W);
    res_data = res_sat ? '1 : res[W-1:0];
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        in_ready = 1'b1;
        if (in_valid) state_nx = MAC;
      end
      (state == MAC): begin
        if (last) state_nx = OUT;
      end
      (state == OUT): begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_ready & in_valid;
  assign cwr    = coef_we & in_ready
                & ({1'b0, coef_addr} < (AW + 1)'(H));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Delay line, coefficient RAM, accumulator and output hold registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) d[i] <= '0;
      for (int i = 0; i < H; i++) c[i] <= '0;
      acc      <= '0;
      idx      <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (cwr) c[coef_addr] <= coef_data;
      if (accept) begin
        d[0] <= in_data;
        for (int i = 1; i < NTAPS; i++) d[i] <= d[i-1];
        acc <= '0;
        idx <= '0;
      end
      if (state == MAC) begin
        acc <= acc_nx;
        idx <= idx + AW'(1);
        if (last) begin
          out_data <= res_data;
          out_sat  <= res_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_sym_fir_serial.sv
// tb_sym_fir_serial: scoreboard bench for sym_fir_serial.
// Small 5-tap instances for directed cases, 39-tap instance for streaming.
module tb_sym_fir_serial;

  localparam int SN = 5;
  localparam int SW = 8;
  localparam int SCW = 8;
  localparam int SH = 3;
  localparam int BN = 39;
  localparam int BW = 12;
  localparam int BCW = 12;
  localparam int BH = 20;
  localparam int BSHIFT = 16;

  typedef longint darr_t [39];
  typedef longint carr_t [20];
  typedef struct {
    longint data;
    bit     sat;
    longint k;
  } exp_t;

  logic clock = 1'b0;
  logic reset;

  logic           in_valid, in_ready, coef_we;
  logic [SW-1:0]  in_data;
  logic [1:0]     coef_addr;
  logic [SCW-1:0] coef_data;
  logic           out_valid, out_ready, out_sat;
  logic [SW-1:0]  out_data;

  logic           s16_in_ready, s16_out_valid, s16_out_sat;
  logic [SW-1:0]  s16_out_data;

  logic           b_in_valid, b_in_ready, b_coef_we;
  logic [BW-1:0]  b_in_data;
  logic [4:0]     b_coef_addr;
  logic [BCW-1:0] b_coef_data;
  logic           b_out_valid, b_out_ready, b_out_sat;
  logic [BW-1:0]  b_out_data;

  exp_t   sq[$];
  exp_t   bq[$];
  darr_t  sd, bd;
  carr_t  sc, bc;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     b_popped = 0;
  longint cyc = 0;
  bit     s_prev = 0;
  bit     b_rand = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  sym_fir_serial #(.NTAPS(SN), .W(SW), .CW(SCW), .SHIFT(0)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  sym_fir_serial #(.NTAPS(SN), .W(SW), .CW(SCW), .SHIFT(16)) u_s16 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(s16_in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(s16_out_valid), .out_ready(out_ready),
    .out_data(s16_out_data), .out_sat(s16_out_sat)
  );

  sym_fir_serial #(.NTAPS(BN), .W(BW), .CW(BCW), .SHIFT(BSHIFT)) u_big (
    .clock(clock), .reset(reset),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr),
    .coef_data(b_coef_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sat(b_out_sat)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Direct (unfolded) convolution over all taps, then shift and clip.
  function automatic exp_t model(input int n, input darr_t d,
                                 input carr_t c, input int sh,
                                 input int w, input longint k);
    longint acc, r, mx;
    int     j;
    exp_t   e;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      j = (i < n - 1 - i) ? i : n - 1 - i;
      acc += d[i] * c[j];
    end
    r = acc >> sh;
    mx = (longint'(1) << w) - 1;
    e.sat = (r > mx);
    e.data = e.sat ? mx : r;
    e.k = k;
    return e;
  endfunction

  task automatic s_coef(input int a, input longint v);
    @(negedge clock);
    coef_we = 1'b1;
    coef_addr = 2'(a);
    coef_data = SCW'(v);
    if (a < SH) sc[a] = v;
    @(negedge clock);
    coef_we = 1'b0;
  endtask

  task automatic s_send(input longint v, input bit we = 0,
                        input int a = 0, input longint cd = 0);
    int t;
    t = 0;
    @(negedge clock);
    while (!in_ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) begin
      chk("s_send_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_data = SW'(v);
    if (we) begin
      coef_we = 1'b1;
      coef_addr = 2'(a);
      coef_data = SCW'(cd);
      if (a < SH) sc[a] = cd;
    end
    for (int i = SN - 1; i > 0; i--) sd[i] = sd[i-1];
    sd[0] = v;
    sq.push_back(model(SN, sd, sc, 0, SW, cyc + 1));
    @(negedge clock);
    in_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic s_drain();
    int t;
    t = 0;
    while (sq.size() != 0 && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (sq.size() != 0) chk("s_drain_timeout", sq.size(), 0);
  endtask

  task automatic set_ordy(input logic v);
    @(posedge clock);
    #1;
    out_ready = v;
  endtask

  task automatic b_coef(input int a, input longint v);
    @(negedge clock);
    b_coef_we = 1'b1;
    b_coef_addr = 5'(a);
    b_coef_data = BCW'(v);
    if (a < BH) bc[a] = v;
    @(negedge clock);
    b_coef_we = 1'b0;
  endtask

  task automatic b_send(input longint v);
    int t;
    t = 0;
    @(negedge clock);
    while (!b_in_ready && t < 500) begin
      @(negedge clock);
      t++;
    end
    if (!b_in_ready) begin
      chk("b_send_timeout", 0, 1);
      return;
    end
    b_in_valid = 1'b1;
    b_in_data = BW'(v);
    for (int i = BN - 1; i > 0; i--) bd[i] = bd[i-1];
    bd[0] = v;
    bq.push_back(model(BN, bd, bc, BSHIFT, BW, cyc + 1));
    @(negedge clock);
    b_in_valid = 1'b0;
  endtask

  // Small-instance monitor: latency on first valid cycle, data on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && out_valid) begin
        if (sq.size() == 0) begin
          if (!s_prev) chk("s_unexpected", 1, 0);
        end else begin
          if (!s_prev) chk("s_latency", cyc - sq[0].k, SH);
          if (out_ready) begin
            e = sq.pop_front();
            chk("s_data", out_data, e.data);
            chk("s_sat", out_sat, e.sat);
          end
        end
      end
      s_prev = out_valid && !out_ready && !reset;
    end
  end

  // Streaming-instance monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && b_out_valid && b_out_ready) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 1, 0);
        end else begin
          e = bq.pop_front();
          chk("b_data", b_out_data, e.data);
          chk("b_sat", b_out_sat, e.sat);
          b_popped++;
        end
      end
    end
  end

  // Random consumer backpressure for the streaming instance.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (b_rand) b_out_ready = 1'($urandom_range(0, 1));
      else        b_out_ready = 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    longint hold_d;
    reset = 1'b1;
    in_valid = 0; in_data = 0; coef_we = 0;
    coef_addr = 0; coef_data = 0; out_ready = 1'b1;
    b_in_valid = 0; b_in_data = 0; b_coef_we = 0;
    b_coef_addr = 0; b_coef_data = 0; b_out_ready = 1'b1;
    for (int i = 0; i < 39; i++) begin sd[i] = 0; bd[i] = 0; end
    for (int i = 0; i < 20; i++) begin sc[i] = 0; bc[i] = 0; end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_s16_ready", s16_in_ready, 1);
    chk("rst_s16_valid", s16_out_valid, 0);

    // Impulse response with c = {1,2,4}.
    s_coef(0, 1);
    s_coef(1, 2);
    s_coef(2, 4);
    s_coef(3, 77);
    s_send(1);
    for (int i = 0; i < 5; i++) s_send(0);
    s_drain();
    chk("imp_tail_data", out_data, 0);

    // Full-scale input with full-scale coefficients.
    for (int i = 0; i < SH; i++) s_coef(i, 255);
    for (int i = 0; i < 5; i++) s_send(255);
    s_drain();
    chk("sat_data", out_data, 255);
    chk("sat_flag", out_sat, 1);
    chk("s16_data", s16_out_data, 4);
    chk("s16_flag", s16_out_sat, 0);

    // Backpressure: result held for 10 cycles, offered sample ignored.
    set_ordy(1'b0);
    s_send(7);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("bp_valid_seen", out_valid, 1);
    hold_d = (sq.size() != 0) ? sq[0].data : -1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data = 8'd99;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, hold_d);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    set_ordy(1'b1);
    s_send(99);
    s_drain();

    // Coefficient gating: writes during MAC dropped, idle writes apply.
    s_coef(0, 1);
    s_coef(1, 2);
    s_coef(2, 4);
    for (int i = 0; i < 5; i++) s_send(0);
    s_send(3);
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_data = 8'd9;
    @(negedge clock);
    coef_we = 1'b0;
    s_send(2);
    s_send(5, 1'b1, 0, 9);
    s_drain();

    // Reset in the middle of accumulation.
    s_send(6);
    @(negedge clock);
    reset = 1'b1;
    sq.delete();
    for (int i = 0; i < 39; i++) begin sd[i] = 0; bd[i] = 0; end
    for (int i = 0; i < 20; i++) begin sc[i] = 0; bc[i] = 0; end
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_data", out_data, 0);
    s_coef(0, 1);
    s_coef(1, 2);
    s_coef(2, 4);
    s_send(1);
    s_drain();
    chk("mid_rst_impulse", out_data, 1);

    // 39-tap streaming with random gaps and random backpressure.
    for (int i = 0; i < BH; i++) b_coef(i, $urandom_range(0, 4095));
    b_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clock);
      b_send($urandom_range(0, 4095));
    end
    b_rand = 1'b0;
    t = 0;
    while (bq.size() != 0 && t < 5000) begin
      @(negedge clock);
      t++;
    end
    chk("b_drain_left", bq.size(), 0);
    chk("b_count", b_popped, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
